onehot_event_scheduler: RTL and testbench

Captures rising edges on eight asynchronous request lines, queues them as pending events, and issues them one at a time as a strictly one-hot 8-bit vector with valid/ready handshake. Sits directly upstream of the 8-to-3 one-hot encoder. Guarantees the encoder only ever sees a single set bit while valid, never the invalid/default input. Round-robin issue order prevents one chattering line from starving the others.

---
 rtl/onehot_event_scheduler_pkg.sv | 17 +
 rtl/onehot_event_scheduler_if.sv | 23 ++
 rtl/onehot_sync_rise.sv | 30 +++
 rtl/onehot_event_scheduler.sv | 93 +++++++++
 tb/tb_onehot_event_scheduler.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/onehot_event_scheduler_pkg.sv
// rtl/onehot_event_scheduler_pkg.sv - shared widths, pointer reset value and one-hot helper
package onehot_event_scheduler_pkg;

    localparam int ONEHOT_W = 8;
    localparam int CODE_W   = 3;

    typedef logic [CODE_W-1:0]   code_t;
    typedef logic [ONEHOT_W-1:0] onehot_t;

    // Pointer resets to the last line so the first search starts at line 0.
    localparam code_t PTR_RST = code_t'(ONEHOT_W - 1);

    function automatic onehot_t code_to_onehot(input code_t code);
        return onehot_t'(1) << code;
    endfunction

endpackage

// File: rtl/onehot_event_scheduler_if.sv
// rtl/onehot_event_scheduler_if.sv - issued-event handshake between scheduler and encoder
// out_onehot : issued event, one bit set while out_valid
// out_valid  : slot holds an event
// out_ready  : consumer accepts the event this cycle
interface onehot_event_scheduler_if #(
    parameter int N = 8
) ();
    logic [N-1:0] out_onehot;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_onehot,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_onehot,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/onehot_sync_rise.sv
// rtl/onehot_sync_rise.sv - per-line synchronizer with rising-edge detect
// clk, rst_n : clock, asynchronous active-low reset
// i_async    : asynchronous level input
// o_rise     : one-cycle pulse on a synchronized 0->1 transition
module onehot_sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // prev starts at 0, so a line held high through reset release yields one event.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/onehot_event_scheduler.sv
// rtl/onehot_event_scheduler.sv - captures request edges and issues them one-hot, round-robin
// clk, rst_n : clock, asynchronous active-low reset
// req_in     : asynchronous request lines, each rising edge is one event
// ovr_clr    : pulse clears all overrun flags
// pending    : events captured but not yet loaded into the output slot
// overrun    : sticky per-line lost-event flags
// out_if     : issued one-hot event with valid/ready handshake
module onehot_event_scheduler
    import onehot_event_scheduler_pkg::*;
#(
    parameter int N           = ONEHOT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             req_in,
    input  logic                     ovr_clr,
    output logic [N-1:0]             pending,
    output logic [N-1:0]             overrun,
    onehot_event_scheduler_if.master out_if
);

    logic [N-1:0] w_rise;
    logic [N-1:0] w_load_mask;
    logic         w_load;
    logic         w_found;
    code_t        w_sel;

    logic [N-1:0] r_pending;
    logic [N-1:0] r_overrun;
    logic [N-1:0] r_onehot;
    logic         r_valid;
    code_t        r_ptr;

    for (genvar g = 0; g < N; g++) begin : g_line
        onehot_sync_rise #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_async(req_in[g]),
            .o_rise (w_rise[g])
        );
    end

    // Round-robin search from ptr+1; the 3-bit add wraps N-1 -> 0, and the
    // last candidate (k == N) is ptr itself.
    always_comb begin
        code_t cand;
        w_found = 1'b0;
        w_sel   = r_ptr;
        cand    = r_ptr;
        for (int k = 1; k <= N; k++) begin
            cand = r_ptr + code_t'(k);
            if (!w_found && r_pending[cand]) begin
                w_found = 1'b1;
                w_sel   = cand;
            end
        end
    end

    assign w_load      = w_found && (!r_valid || out_if.out_ready);
    assign w_load_mask = w_load ? N'(code_to_onehot(w_sel)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_overrun <= '0;
            r_onehot  <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= PTR_RST;
        end else begin
            // A rise on the line being loaded this edge becomes a fresh pending event.
            r_pending <= (r_pending & ~w_load_mask) | w_rise;
            // New overruns win over a coincident clear.
            r_overrun <= (ovr_clr ? '0 : r_overrun) | (w_rise & r_pending & ~w_load_mask);
            if (w_load) begin
                r_onehot <= w_load_mask;
                r_valid  <= 1'b1;
                r_ptr    <= w_sel;
            end else if (r_valid && out_if.out_ready) begin
                r_onehot <= '0;
                r_valid  <= 1'b0;
            end
        end
    end

    assign pending           = r_pending;
    assign overrun           = r_overrun;
    assign out_if.out_onehot = r_onehot;
    assign out_if.out_valid  = r_valid;

endmodule

// File: tb/tb_onehot_event_scheduler.sv
// tb/tb_onehot_event_scheduler.sv - directed vector bench for onehot_event_scheduler
module tb_onehot_event_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic       ovr_clr;
    logic [7:0] pending;
    logic [7:0] overrun;

    onehot_event_scheduler_if #(.N(8)) bus ();

    onehot_event_scheduler #(.N(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_in (req_in),
        .ovr_clr(ovr_clr),
        .pending(pending),
        .overrun(overrun),
        .out_if (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       clr;
        logic [7:0] oh;
        logic       v;
        logic [7:0] p;
        logic [7:0] o;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int idx, input logic [7:0] oh, input logic v,
                              input logic [7:0] p, input logic [7:0] o);
        logic [7:0] pc;
        chk8({name, ".onehot"}, idx, bus.out_onehot, oh);
        chk8({name, ".valid"}, idx, {7'b0, bus.out_valid}, {7'b0, v});
        chk8({name, ".pending"}, idx, pending, p);
        chk8({name, ".overrun"}, idx, overrun, o);
        pc = 8'($countones(bus.out_onehot));
        chk8({name, ".popcount"}, idx, pc, v ? 8'd1 : 8'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] r, input logic rdy, input logic clr, input logic [7:0] oh,
                       input logic v, input logic [7:0] p, input logic [7:0] o);
        vec_t t;
        t.req = r; t.rdy = rdy; t.clr = clr; t.oh = oh; t.v = v; t.p = p; t.o = o;
        vq.push_back(t);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            req_in        = vq[i].req;
            bus.out_ready = vq[i].rdy;
            ovr_clr       = vq[i].clr;
            tick();
            check_outs(name, i + 1, vq[i].oh, vq[i].v, vq[i].p, vq[i].o);
        end
        vq.delete();
    endtask

    task automatic do_reset(input string name);
        rst_n         = 1'b0;
        req_in        = 8'h00;
        bus.out_ready = 1'b0;
        ovr_clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outs(name, 0, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        logic [7:0] m;
        logic [7:0] pm;

        // Single event latency: out_valid at edge 4, one cycle wide.
        do_reset("reset");
        add(8'h04, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h04, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h04, 1, 0, 8'h00, 0, 8'h04, 8'h00);
        add(8'h00, 1, 0, 8'h04, 1, 8'h00, 8'h00);
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        run_table("single");

        // All lines at once: back-to-back issue in line order.
        do_reset("reset_all");
        add(8'hFF, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'hFF, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'hFF, 1, 0, 8'h00, 0, 8'hFF, 8'h00);
        for (int k = 0; k < 8; k++) begin
            m  = 8'h01 << k;
            pm = 8'hFF << (k + 1);
            add(8'hFF, 1, 0, m, 1, pm, 8'h00);
        end
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        run_table("all");

        // Line 5 held in slot: second rise pends, third overruns.
        do_reset("reset_ovr");
        add(8'h20, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h20, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h00, 0, 0, 8'h00, 0, 8'h20, 8'h00);
        add(8'h00, 0, 0, 8'h20, 1, 8'h00, 8'h00);
        add(8'h20, 0, 0, 8'h20, 1, 8'h00, 8'h00);
        add(8'h20, 0, 0, 8'h20, 1, 8'h00, 8'h00);
        add(8'h00, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(8'h00, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(8'h20, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(8'h20, 0, 0, 8'h20, 1, 8'h20, 8'h00);
        add(8'h00, 0, 0, 8'h20, 1, 8'h20, 8'h20);
        add(8'h00, 0, 0, 8'h20, 1, 8'h20, 8'h20);
        add(8'h00, 1, 0, 8'h20, 1, 8'h00, 8'h20);
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h20);
        add(8'h00, 1, 1, 8'h00, 0, 8'h00, 8'h00);
        run_table("ovr5");

        // Pointer at line 6, pending 41: wrap to line 0 first, then line 6.
        do_reset("reset_wrap");
        add(8'h40, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h40, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        add(8'h00, 0, 0, 8'h00, 0, 8'h40, 8'h00);
        add(8'h00, 0, 0, 8'h40, 1, 8'h00, 8'h00);
        add(8'h41, 0, 0, 8'h40, 1, 8'h00, 8'h00);
        add(8'h41, 0, 0, 8'h40, 1, 8'h00, 8'h00);
        add(8'h00, 0, 0, 8'h40, 1, 8'h41, 8'h00);
        add(8'h00, 1, 0, 8'h01, 1, 8'h40, 8'h00);
        add(8'h00, 1, 0, 8'h40, 1, 8'h00, 8'h00);
        add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        run_table("wrap");

        // Clear coincident with a new overrun on line 2: set wins.
        do_reset("reset_clr");
        for (int c = 1; c <= 16; c++) begin
            req_in  = (((c - 1) % 4) < 2) ? 8'h04 : 8'h00;
            ovr_clr = (c == 15 || c == 16);
            tick();
            if (c == 11) chk8("clr.first_ovr", c, overrun, 8'h04);
            if (c == 14) chk8("clr.before", c, overrun, 8'h04);
            if (c == 15) begin
                chk8("clr.race", c, overrun, 8'h04);
                chk8("clr.slot", c, bus.out_onehot, 8'h04);
                chk8("clr.pend", c, pending, 8'h04);
            end
            if (c == 16) chk8("clr.plain", c, overrun, 8'h00);
        end
        ovr_clr = 1'b0;

        // Asynchronous reset while slot is full and pending=18.
        do_reset("reset_async");
        for (int c = 1; c <= 7; c++) begin
            req_in = (c <= 2) ? 8'h01 : ((c == 5 || c == 6) ? 8'h18 : 8'h00);
            tick();
        end
        check_outs("pre_async", 7, 8'h01, 1'b1, 8'h18, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async", 0, 8'h00, 1'b0, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) add(8'h00, 1, 0, 8'h00, 0, 8'h00, 8'h00);
        run_table("post_async");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
